spi_bus_arbiter: RTL

Shares the single external SPI flash bus between the streaming read engine (`spi_stream`) and a direct-access master, such as the boot loader or a software SPI port. The arbiter drives a pause handshake so the stream engine stops cleanly at a word boundary. It then holds the bus idle for a guard interval and grants the direct master. When the direct master releases the bus, it restores stream ownership after a second guard interval. The block sits between both masters' pin-level SPI signals and the chip's SPI pads.

---
 rtl/spi_bus_arbiter.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/spi_bus_arbiter.sv
// ----------------------------------------------------------------------------
// spi_bus_arbiter
//
// Shares the single external SPI flash bus between the streaming read engine
// (spi_stream) and a direct-access master such as the boot loader or a
// software SPI port.
//
// Before the direct master gets the bus, the stream engine is asked to pause
// at a word boundary. The bus is then held idle (CS high) for a guard
// interval, and only after that is the direct master granted. When the direct
// master lets go, the bus is held idle for a second guard interval before the
// stream engine owns it again.
//
// Optional feature, selected by the macro SPI_BUS_ARB_TIMEOUT_EN:
//   defined   - a pause request that goes unacknowledged for TIMEOUT_CYCLES
//               clocks is abandoned. It raises the sticky err_timeout flag
//               and blocks further requests until d_req has been seen low.
//   undefined - the arbiter waits for pause_ack indefinitely. err_timeout is
//               tied low and err_clr is ignored.
//
// Parameters:
//   GUARD_CYCLES    idle bus cycles on every ownership change (1..255)
//   TIMEOUT_CYCLES  pause_ack wait limit, timeout build only (1..65535)
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   s_cs_n, s_sck, s_mosi      stream engine pin outputs
//   s_miso                     MISO returned to the stream engine
//   pause_req, pause_ack       pause handshake with the stream engine
//   d_req, d_gnt               direct master request / grant
//   d_cs_n, d_sck, d_mosi      direct master pin outputs
//   d_miso                     MISO returned to the direct master
//   spi_cs_n, spi_sck,
//   spi_mosi, spi_miso         chip SPI pads
//   err_timeout, err_clr       sticky pause-timeout flag and its clear pulse
// ----------------------------------------------------------------------------
module spi_bus_arbiter #(
   parameter int unsigned GUARD_CYCLES   = 4,
   parameter int unsigned TIMEOUT_CYCLES = 1023
) (
   input  logic clk,
   input  logic rst_n,
   input  logic s_cs_n,
   input  logic s_sck,
   input  logic s_mosi,
   output logic s_miso,
   output logic pause_req,
   input  logic pause_ack,
   input  logic d_req,
   output logic d_gnt,
   input  logic d_cs_n,
   input  logic d_sck,
   input  logic d_mosi,
   output logic d_miso,
   output logic spi_cs_n,
   output logic spi_sck,
   output logic spi_mosi,
   input  logic spi_miso,
   output logic err_timeout,
   input  logic err_clr
);

   typedef enum logic [2:0] {
      ST_STREAM,
      ST_PAUSE,
      ST_GUARD_IN,
      ST_DIRECT,
      ST_GUARD_OUT
   } state_t;

   // The guard counter counts down to zero, so it is loaded with one less
   // than the number of idle cycles wanted.
   localparam logic [7:0] GUARD_LAST = 8'(GUARD_CYCLES - 1);

   state_t     state_q;
   state_t     state_d;
   logic [7:0] guard_q;
   logic [7:0] guard_d;
   logic       blocked;
   logic       timeout_hit;

`ifdef SPI_BUS_ARB_TIMEOUT_EN
   localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

   logic [15:0] to_cnt_q;
   logic        block_q;
   logic        err_q;

   // The timeout fires in the last allowed pause cycle. This is a cycle in
   // which the request is still up and no acknowledge has arrived.
   assign timeout_hit = (state_q == ST_PAUSE) && d_req && !pause_ack &&
                        (to_cnt_q == TIMEOUT_LAST);

   // The wait counter is kept at zero while streaming, so that every new
   // pause request starts from a clean count. It then counts the cycles
   // spent in the pause state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         to_cnt_q <= '0;
      end else if (state_q == ST_STREAM) begin
         to_cnt_q <= '0;
      end else if ((state_q == ST_PAUSE) && !timeout_hit) begin
         to_cnt_q <= to_cnt_q + 16'd1;
      end
   end

   // After a timeout, requests are ignored until the direct master drops
   // d_req. This stops a master that is still asserting d_req from
   // re-requesting over and over. err_clr takes priority over a new timeout
   // in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         block_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         if (timeout_hit) begin
            block_q <= 1'b1;
         end else if (!d_req) begin
            block_q <= 1'b0;
         end
         if (err_clr) begin
            err_q <= 1'b0;
         end else if (timeout_hit) begin
            err_q <= 1'b1;
         end
      end
   end

   assign blocked     = block_q;
   assign err_timeout = err_q;
`else
   logic unused_cfg;

   assign timeout_hit = 1'b0;
   assign blocked     = 1'b0;
   assign err_timeout = 1'b0;
   assign unused_cfg  = &{1'b0, err_clr, (TIMEOUT_CYCLES != 0)};
`endif

   // State and guard counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_STREAM;
         guard_q <= '0;
      end else begin
         state_q <= state_d;
         guard_q <= guard_d;
      end
   end

   // Next-state logic. If the request is dropped during the inbound guard,
   // the arbiter goes straight to the outbound guard with a fresh count.
   // This way the stream engine always sees a full idle period before it
   // resumes. pause_ack is only looked at in the pause state; once the
   // guard has started, the stream engine is not allowed to resume, whatever
   // it signals.
   always_comb begin
      state_d = state_q;
      guard_d = guard_q;
      case (state_q)
         ST_STREAM: begin
            if (d_req && !blocked) begin
               state_d = ST_PAUSE;
            end
         end
         ST_PAUSE: begin
            if (!d_req) begin
               state_d = ST_STREAM;
            end else if (pause_ack) begin
               state_d = ST_GUARD_IN;
               guard_d = GUARD_LAST;
            end else if (timeout_hit) begin
               state_d = ST_STREAM;
            end
         end
         ST_GUARD_IN: begin
            if (!d_req) begin
               state_d = ST_GUARD_OUT;
               guard_d = GUARD_LAST;
            end else if (guard_q == 8'd0) begin
               state_d = ST_DIRECT;
            end else begin
               guard_d = guard_q - 8'd1;
            end
         end
         ST_DIRECT: begin
            if (!d_req) begin
               state_d = ST_GUARD_OUT;
               guard_d = GUARD_LAST;
            end
         end
         ST_GUARD_OUT: begin
            if (guard_q == 8'd0) begin
               state_d = ST_STREAM;
            end else begin
               guard_d = guard_q - 8'd1;
            end
         end
         default: begin
            state_d = ST_STREAM;
         end
      endcase
   end

   // Pad mux and MISO demux. These depend only on the registered state,
   // never on d_req, so the pads cannot glitch on a request edge. A master
   // that does not own the bus sees MISO held at 0. In the guard states the
   // pads are parked idle.
   always_comb begin
      pause_req = 1'b1;
      d_gnt     = 1'b0;
      spi_cs_n  = 1'b1;
      spi_sck   = 1'b0;
      spi_mosi  = 1'b0;
      s_miso    = 1'b0;
      d_miso    = 1'b0;
      case (state_q)
         ST_STREAM, ST_PAUSE: begin
            pause_req = (state_q == ST_PAUSE);
            spi_cs_n  = s_cs_n;
            spi_sck   = s_sck;
            spi_mosi  = s_mosi;
            s_miso    = spi_miso;
         end
         ST_DIRECT: begin
            d_gnt    = 1'b1;
            spi_cs_n = d_cs_n;
            spi_sck  = d_sck;
            spi_mosi = d_mosi;
            d_miso   = spi_miso;
         end
         default: begin
         end
      endcase
   end

endmodule
